// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format encodings and helpers for the immediate encoder and
// the pipeline's immediate sign-extension decoder.
package imm_encoder_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam int ERR_COUNT_W = 16;

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    // Sign-extension decode, identical to the pipeline decoder.
    function automatic logic [31:0] decode_imm(input logic [31:0] inst, input logic [1:0] src);
        logic [31:0] imm;
        imm = '0;
        case (src)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J: imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational scatter of a signed immediate into the I/S/B/J instruction
// fields of a base word, with range and alignment error detection.
module imm_field_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [1:0]  imm_src,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        inst = base;
        err  = 1'b0;
        case (imm_src)
            IMM_I: begin
                inst[31:20] = imm[11:0];
                err         = !fits_signed(imm, 12);
            end
            IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = !fits_signed(imm, 12);
            end
            IMM_B: begin
                inst[31]    = imm[12];
                inst[7]     = imm[11];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                err         = !fits_signed(imm, 13) || imm[0];
            end
            IMM_J: begin
                inst[31]    = imm[20];
                inst[19:12] = imm[19:12];
                inst[20]    = imm[11];
                inst[30:21] = imm[10:1];
                err         = !fits_signed(imm, 21) || imm[0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder with valid/ready handshake and a saturating
// error counter. Define IMM_ENCODER_ROUNDTRIP_CHECK_EN to add the decode-back check.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_base,
    input  logic [31:0]            in_imm,
    input  logic [1:0]             in_imm_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic                   out_err,
    input  logic                   err_clr,
    output logic [ERR_COUNT_W-1:0] err_count
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    ,
    output logic                   roundtrip_fail
`endif
);

    logic [31:0]            pack_inst;
    logic                   pack_err;
    logic                   s1_valid;
    logic [31:0]            s1_inst;
    logic                   s1_err;
    logic                   s2_load;
    logic                   s2_err_in;
    logic                   deliver_err;
    logic [ERR_COUNT_W-1:0] err_cnt_q;

    imm_field_pack u_pack (
        .base    (in_base),
        .imm     (in_imm),
        .imm_src (in_imm_src),
        .inst    (pack_inst),
        .err     (pack_err)
    );

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_inst <= pack_inst;
                s1_err  <= pack_err;
            end
        end
    end

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    logic [31:0] s1_imm;
    logic [1:0]  s1_src;
    logic        rt_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_imm <= '0;
            s1_src <= IMM_I;
        end else if (in_ready && in_valid) begin
            s1_imm <= in_imm;
            s1_src <= in_imm_src;
        end
    end

    // s1_inst is exactly what S2 presents on out_inst, so decoding it here checks the output word.
    assign rt_mismatch = decode_imm(s1_inst, s1_src) != s1_imm;
    assign s2_err_in   = s1_err || rt_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roundtrip_fail <= 1'b0;
        end else if (s2_load && s1_valid && rt_mismatch) begin
            roundtrip_fail <= 1'b1;
        end else if (err_clr) begin
            roundtrip_fail <= 1'b0;
        end
    end
`else
    assign s2_err_in = s1_err;
`endif

    // Payload only moves with a valid word, so an empty S2 keeps its last contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= s1_inst;
                out_err  <= s2_err_in;
            end
        end
    end

    assign deliver_err = out_valid && out_ready && out_err;

    // A clear coinciding with an errored delivery leaves that delivery counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= deliver_err ? ERR_COUNT_W'(1) : '0;
        end else if (deliver_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: bit-map reference model, scoreboard and
// directed vectors. Build with IMM_ENCODER_ROUNDTRIP_CHECK_EN to cover roundtrip_fail.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic [1:0]  in_imm_src = IMM_I;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic        err_clr = 1'b0;
    logic [15:0] err_count;
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    logic        roundtrip_fail;
`endif

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
        ,
        .roundtrip_fail (roundtrip_fail)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Which immediate bit lands in instruction bit k, or -1 if k comes from base.
    function automatic int imm_bit_for(input logic [1:0] f, input int k);
        case (f)
            IMM_I: return (k >= 20) ? k - 20 : -1;
            IMM_S: begin
                if (k >= 25) return k - 20;
                if (k >= 7 && k <= 11) return k - 7;
                return -1;
            end
            IMM_B: begin
                if (k == 31) return 12;
                if (k == 7) return 11;
                if (k >= 25 && k <= 30) return k - 20;
                if (k >= 8 && k <= 11) return k - 7;
                return -1;
            end
            default: begin
                if (k == 31) return 20;
                if (k >= 12 && k <= 19) return k;
                if (k == 20) return 11;
                if (k >= 21 && k <= 30) return k - 20;
                return -1;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] base, input logic [31:0] imm,
                                               input logic [1:0] f);
        logic [31:0] r;
        int src;
        r = base;
        for (int k = 0; k < 32; k++) begin
            src = imm_bit_for(f, k);
            if (src >= 0) r[k] = imm[src];
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [31:0] imm, input logic [1:0] f);
        longint v;
        v = longint'($signed(imm));
        case (f)
            IMM_I, IMM_S: return (v < -2048) || (v > 2047);
            IMM_B:        return (v < -4096) || (v > 4095) || imm[0];
            default:      return (v < -64'sd1048576) || (v > 64'sd1048575) || imm[0];
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_cnt = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst;
    logic        prev_err;

    // Scoreboard: inputs and outputs are sampled at negedge, the edge after fires them.
    always @(negedge clk) begin
        exp_t e;
        logic fired_err;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt  = '0;
            prev_stall = 1'b0;
        end else begin
            fired_err = 1'b0;
            check("err_count", 32'(err_count), 32'(model_cnt));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_inst", out_inst, prev_inst);
                check("hold_err", 32'(out_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_word: got %08h, expected no word (t=%0t)", out_inst, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_inst", out_inst, e.inst);
                    check("stream_err", 32'(out_err), 32'(e.err));
                    fired_err = e.err;
                end
            end
            if (err_clr) model_cnt = fired_err ? 16'd1 : 16'd0;
            else if (fired_err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            prev_stall = out_valid && !out_ready;
            prev_inst  = out_inst;
            prev_err   = out_err;
            if (in_valid && in_ready) begin
                e.inst = model_inst(in_base, in_imm, in_imm_src);
                e.err  = model_err(in_imm, in_imm_src);
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [1:0] f);
        logic fire;
        in_valid   = 1'b1;
        in_base    = base;
        in_imm     = imm;
        in_imm_src = f;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) return;
        end
        timeout("send_accept");
    endtask

    task automatic run_one(input string name, input logic [31:0] base, input logic [31:0] imm,
                           input logic [1:0] f, input logic [31:0] exp_inst, input logic exp_err);
        bit seen;
        send(base, imm, f);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) timeout(name);
        else begin
            check({name, "_inst"}, out_inst, exp_inst);
            check({name, "_err"}, 32'(out_err), 32'(exp_err));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        if (!done) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {{20{r[11]}}, r[11:0]};
            2:       return {{11{r[20]}}, r[20:1], 1'b0};
            default: return r & 32'h0000_1FFF;
        endcase
    endfunction

    bit stream_done = 1'b0;

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model against hand-computed words.
        check("model_i", model_inst(32'h13, 32'hFFFFF800, IMM_I), 32'h80000013);
        check("model_b", model_inst(32'h63, 32'hFFFFFFFC, IMM_B), 32'hFE000EE3);
        check("model_j", model_inst(32'h6F, 32'h00000800, IMM_J), 32'h0010006F);
        check("model_j_err", 32'(model_err(32'h00100000, IMM_J)), 32'd1);

        // Latency: accepted at edge N, visible right after edge N+1.
        in_valid = 1'b1; in_base = 32'h13; in_imm = 32'hFFFFF800; in_imm_src = IMM_I;
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_n_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n1_valid", 32'(out_valid), 32'd1);
        check("lat_n1_inst", out_inst, 32'h80000013);
        check("lat_n1_err", 32'(out_err), 32'd0);
        drain();
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
        check("rt_clean", 32'(roundtrip_fail), 32'd0);
`endif

        run_one("b_ok", 32'h63, 32'hFFFFFFFC, IMM_B, 32'hFE000EE3, 1'b0);
        run_one("b_odd", 32'h63, 32'h00000003, IMM_B, 32'h00000163, 1'b1);
        @(negedge clk);
        check("b_odd_count", 32'(err_count), 32'd1);
        @(posedge clk); #1;
        run_one("j_ok", 32'h6F, 32'h00000800, IMM_J, 32'h0010006F, 1'b0);
        run_one("j_range", 32'h6F, 32'h00100000, IMM_J, 32'h8000006F, 1'b1);
        run_one("s_ok", 32'h23, 32'hFFFFF81F, IMM_S, 32'h80000FA3, 1'b0);

        // Clear count (and sticky flag) with an empty pipeline.
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;

        // Stall: errored I word held while out_ready=0.
        out_ready = 1'b0;
        send(32'h13, 32'h00000800, IMM_I);
        send(32'h13, 32'h00000005, IMM_I);
        in_valid = 1'b1; in_base = 32'h6F; in_imm = 32'h0000_0010; in_imm_src = IMM_J;
        repeat (5) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("stall_inst", out_inst, 32'h80000013);
            check("stall_err", 32'(out_err), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h6F, 32'h0000_0010, IMM_J);
        in_valid = 1'b0;
        drain();
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
        check("rt_sticky", 32'(roundtrip_fail), 32'd1);
`endif

        // 64-word stream with random back-pressure.
        fork
            begin
                for (int i = 0; i < 64; i++) send($urandom, pick_imm(), 2'(i % 4));
                in_valid = 1'b0;
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Saturation at 0xFFFF.
        force dut.err_cnt_q = 16'hFFFF;
        model_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.err_cnt_q;
        run_one("sat_word", 32'h13, 32'h00000800, IMM_I, 32'h80000013, 1'b1);
        @(negedge clk);
        check("sat_count", 32'(err_count), 32'hFFFF);
        @(posedge clk); #1;

        // err_clr coinciding with an errored delivery.
        out_ready = 1'b0;
        send(32'h13, 32'h00000800, IMM_I);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        err_clr   = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_inc_count", 32'(err_count), 32'd1);
        @(posedge clk); #1;

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(32'h13, 32'h00000001, IMM_I);
        send(32'h13, 32'h00000002, IMM_I);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_empty", 32'(out_valid), 32'd0);
        end
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
